ps2_scancode_decoder: RTL and testbench
=======================================

Name: ps2_scancode_decoder

Overview:
- Downstream consumer of the PS/2 receive byte stream delivered by ps2_controller: takes raw Set-2 scancode bytes and assembles them into complete key events.
- Handles the make, break (F0), extended (E0) and Pause (E1) sequences, tracks modifier/lock state, and queues events in a small FIFO for the CPU-side or VGA-terminal logic.
- Sits between the PS/2 byte receiver and the Avalon-facing keyboard peripheral logic.

Parameters:
- FIFO_DEPTH, 8, number of queued key events; power of two, 2..64.
- FIFO_AW, 3, log2(FIFO_DEPTH); must match FIFO_DEPTH.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx_data  input  8  received PS/2 byte; valid only when rx_valid=1.
- rx_valid  input  1  single-cycle strobe, one per received byte.
- evt_ready  input  1  consumer pops the head event when evt_valid=1 and evt_ready=1.
- ovf_clear  input  1  clears the sticky overflow flag.
- evt_valid  output  1  FIFO non-empty.
- evt_code  output  8  head event scancode (final byte of the sequence).
- evt_ext  output  1  head event had the E0 prefix.
- evt_break  output  1  head event is a release (F0 seen).
- evt_ascii  output  8  head event ASCII; 0 if the key is unmapped. See Optional Feature.
- mod_shift  output  1  left (12) or right (59) shift currently held.
- mod_ctrl  output  1  left (14) or right (E0 14) ctrl held.
- mod_alt  output  1  left (11) or right (E0 11) alt held.
- caps_lock  output  1  caps-lock toggle state.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
Reset:
- Asynchronous, active-high.
- FSM goes to IDLE, FIFO empties, and every output is 0. evt_code, evt_ascii, evt_ext and evt_break all show 0 while the FIFO is empty.
- Reset mid-sequence discards any partial prefix state.

FSM (advances only on cycles with rx_valid=1):
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE, with skip counter = 7.
  - AA, FA, FE, EE, FC, 00, FF are controller/status bytes: stay in IDLE, no event.
  - Any other byte: push make event {ext=0, brk=0, code}; stay in IDLE.
- EXT:
  - F0 -> EXTBRK.
  - 12 or 59 (print-screen fake shift): discard, -> IDLE.
  - Any other byte: push {ext=1, brk=0}, -> IDLE.
- BRK:
  - Any byte: push {ext=0, brk=1}, -> IDLE.
- EXTBRK:
  - 12 or 59: discard, -> IDLE.
  - Any other byte: push {ext=1, brk=1}, -> IDLE.
- PAUSE:
  - Discard bytes and decrement the skip counter.
  - When the counter reaches 0, push one event {ext=1, brk=0, code=E1}, -> IDLE.
- In BRK, EXT and EXTBRK, the bytes FA, AA, FC and FE abort the sequence to IDLE with no event.

Modifiers and caps lock:
- Updated in the same cycle the event is pushed, from {ext, brk, code}.
- Each side of shift/ctrl/alt is tracked separately; a mod_* output is the OR of its two sides.
- caps_lock toggles on a make of 58 only if 58 is not already held. Typematic repeats do not toggle it; the break of 58 clears the held bit.

Latency:
- Event is visible on evt_valid and evt_* the cycle after the rx_valid strobe of the final byte.
- Modifier outputs update on that same edge.

FIFO:
- Registered head outputs, FIFO_DEPTH entries of {ext, brk, code, ascii}.
- Push and pop in the same cycle:
  - Non-empty: both occur; occupancy is unchanged.
  - Full: the pop frees a slot and the push is accepted.
  - Empty: the push is accepted; evt_valid rises next cycle.
- Push while full with no pop: the event is dropped and overflow is set.
- overflow holds until ovf_clear. If a set and a clear happen in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH.
- evt_ready while empty is ignored.

Optional Feature:
- Macro: PS2_ASCII_LUT_EN.
- Defined:
  - A combinational Set-2 LUT computes ASCII at push time for non-extended make events.
  - Letters: uppercase when shift XOR caps_lock.
  - Digits and punctuation: shifted forms when shift is held.
  - Enter = 0D, Backspace = 08, Space = 20, Tab = 09, Esc = 1B.
  - Break events, extended events, and unmapped codes give 0.
- Undefined:
  - evt_ascii is constant 0 and no LUT logic is synthesised.
  - All other behaviour is identical.

Test Plan:
- Bytes 1C, F0, 1C -> two events: {ext0, brk0, 1C, ascii 61} then {ext0, brk1, 1C, ascii 00}; evt_valid the cycle after each final byte.
- Bytes 12, 1C, F0, 1C, F0, 12 -> mod_shift=1 after the first byte; the 'A' make gives ascii 41; mod_shift=0 after the final 12; 4 events queued in total.
- Bytes E0, 75, E0, F0, 75 -> {ext1, brk0, 75} then {ext1, brk1, 75}. Separately, E0 12 E0 7C (print screen) -> only {ext1, brk0, 7C}.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one event, code E1; modifiers unchanged. Bytes 58, 58, F0, 58 -> caps_lock=1 after the first make, still 1 after the repeat, unchanged by the break.
- evt_ready=0, 9 makes with FIFO_DEPTH=8 -> 8 queued, overflow=1. Then pop with a simultaneous push while full -> occupancy stays 8. ovf_clear -> overflow=0.
- Reset asserted after F0 is received, then released, then byte 1C -> make event (brk0), not break; all outputs 0 during reset.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode decoder: assembles make/break/E0/E1 sequences into key events
// queued in a small FIFO. Define PS2_ASCII_LUT_EN to enable the ASCII translation table.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       evt_ready,
    input  logic       ovf_clear,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [7:0] evt_ascii,
    output logic       mod_shift,
    output logic       mod_ctrl,
    output logic       mod_alt,
    output logic       caps_lock,
    output logic       overflow
);

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_PAUSE} state_t;

    localparam logic [FIFO_AW:0]   DEPTH_C = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    state_t     state_q, state_d;
    logic [2:0] skip_q, skip_d;
    logic       push;
    logic       push_ext;
    logic       push_brk;
    logic [7:0] push_code;
    logic [7:0] push_ascii;
    logic       is_status, is_abort, is_fake;

    logic lshift_q, rshift_q, lctrl_q, rctrl_q, lalt_q, ralt_q;
    logic caps_q, caps_held_q;
    logic ovf_q;

    logic [17:0]        mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_q, rd_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               full, pop, wr_en;
    logic [17:0]        head;

    always_comb begin
        is_status = (rx_data == 8'hAA) || (rx_data == 8'hFA) || (rx_data == 8'hFE) ||
                    (rx_data == 8'hEE) || (rx_data == 8'hFC) || (rx_data == 8'h00) ||
                    (rx_data == 8'hFF);
        is_abort  = (rx_data == 8'hFA) || (rx_data == 8'hAA) || (rx_data == 8'hFC) ||
                    (rx_data == 8'hFE);
        is_fake   = (rx_data == 8'h12) || (rx_data == 8'h59);
    end

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        push      = 1'b0;
        push_ext  = 1'b0;
        push_brk  = 1'b0;
        push_code = rx_data;
        if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (rx_data == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (rx_data == 8'hE1) begin
                        state_d = S_PAUSE;
                        skip_d  = 3'd7;
                    end else if (!is_status) begin
                        push = 1'b1;
                    end
                end
                S_EXT: begin
                    if (is_abort || is_fake) begin
                        state_d = S_IDLE;
                    end else if (rx_data == 8'hF0) begin
                        state_d = S_EXTBRK;
                    end else begin
                        push     = 1'b1;
                        push_ext = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                S_BRK: begin
                    state_d = S_IDLE;
                    if (!is_abort) begin
                        push     = 1'b1;
                        push_brk = 1'b1;
                    end
                end
                S_EXTBRK: begin
                    state_d = S_IDLE;
                    if (!is_abort && !is_fake) begin
                        push     = 1'b1;
                        push_ext = 1'b1;
                        push_brk = 1'b1;
                    end
                end
                S_PAUSE: begin
                    // The eight-byte Pause sequence collapses into one synthetic E1 event.
                    if (skip_q == 3'd1) begin
                        push      = 1'b1;
                        push_ext  = 1'b1;
                        push_code = 8'hE1;
                        state_d   = S_IDLE;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            skip_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            lctrl_q     <= 1'b0;
            rctrl_q     <= 1'b0;
            lalt_q      <= 1'b0;
            ralt_q      <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
        end else if (push) begin
            case ({push_ext, push_code})
                9'h012: lshift_q <= !push_brk;
                9'h059: rshift_q <= !push_brk;
                9'h014: lctrl_q  <= !push_brk;
                9'h114: rctrl_q  <= !push_brk;
                9'h011: lalt_q   <= !push_brk;
                9'h111: ralt_q   <= !push_brk;
                9'h058: begin
                    // Only the first make after a release toggles; typematic repeats do not.
                    if (push_brk) begin
                        caps_held_q <= 1'b0;
                    end else begin
                        if (!caps_held_q) caps_q <= !caps_q;
                        caps_held_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mod_shift = lshift_q | rshift_q;
    assign mod_ctrl  = lctrl_q | rctrl_q;
    assign mod_alt   = lalt_q | ralt_q;
    assign caps_lock = caps_q;

`ifdef PS2_ASCII_LUT_EN
    function automatic logic [7:0] set2_ascii(input logic [7:0] code, input logic shift,
                                              input logic caps);
        logic [7:0] lo, hi;
        logic       letter;
        lo = 8'h00;
        hi = 8'h00;
        case (code)
            8'h1C: {lo, hi} = {"a", "A"};  8'h32: {lo, hi} = {"b", "B"};
            8'h21: {lo, hi} = {"c", "C"};  8'h23: {lo, hi} = {"d", "D"};
            8'h24: {lo, hi} = {"e", "E"};  8'h2B: {lo, hi} = {"f", "F"};
            8'h34: {lo, hi} = {"g", "G"};  8'h33: {lo, hi} = {"h", "H"};
            8'h43: {lo, hi} = {"i", "I"};  8'h3B: {lo, hi} = {"j", "J"};
            8'h42: {lo, hi} = {"k", "K"};  8'h4B: {lo, hi} = {"l", "L"};
            8'h3A: {lo, hi} = {"m", "M"};  8'h31: {lo, hi} = {"n", "N"};
            8'h44: {lo, hi} = {"o", "O"};  8'h4D: {lo, hi} = {"p", "P"};
            8'h15: {lo, hi} = {"q", "Q"};  8'h2D: {lo, hi} = {"r", "R"};
            8'h1B: {lo, hi} = {"s", "S"};  8'h2C: {lo, hi} = {"t", "T"};
            8'h3C: {lo, hi} = {"u", "U"};  8'h2A: {lo, hi} = {"v", "V"};
            8'h1D: {lo, hi} = {"w", "W"};  8'h22: {lo, hi} = {"x", "X"};
            8'h35: {lo, hi} = {"y", "Y"};  8'h1A: {lo, hi} = {"z", "Z"};
            8'h16: {lo, hi} = {"1", "!"};  8'h1E: {lo, hi} = {"2", "@"};
            8'h26: {lo, hi} = {"3", "#"};  8'h25: {lo, hi} = {"4", "$"};
            8'h2E: {lo, hi} = {"5", "%"};  8'h36: {lo, hi} = {"6", "^"};
            8'h3D: {lo, hi} = {"7", "&"};  8'h3E: {lo, hi} = {"8", "*"};
            8'h46: {lo, hi} = {"9", "("};  8'h45: {lo, hi} = {"0", ")"};
            8'h0E: {lo, hi} = {8'h60, "~"};  8'h4E: {lo, hi} = {"-", "_"};
            8'h55: {lo, hi} = {"=", "+"};  8'h54: {lo, hi} = {"[", "{"};
            8'h5B: {lo, hi} = {"]", "}"};  8'h5D: {lo, hi} = {"\\", "|"};
            8'h4C: {lo, hi} = {";", ":"};  8'h52: {lo, hi} = {"'", "\""};
            8'h41: {lo, hi} = {",", "<"};  8'h49: {lo, hi} = {".", ">"};
            8'h4A: {lo, hi} = {"/", "?"};
            8'h5A: {lo, hi} = {8'h0D, 8'h0D};  8'h66: {lo, hi} = {8'h08, 8'h08};
            8'h29: {lo, hi} = {8'h20, 8'h20};  8'h0D: {lo, hi} = {8'h09, 8'h09};
            8'h76: {lo, hi} = {8'h1B, 8'h1B};
            default: {lo, hi} = 16'h0000;
        endcase
        letter = (lo >= "a") && (lo <= "z");
        if (letter) return (shift ^ caps) ? hi : lo;
        return shift ? hi : lo;
    endfunction

    assign push_ascii = (push_ext || push_brk) ? 8'h00 : set2_ascii(push_code, mod_shift, caps_q);
`else
    assign push_ascii = 8'h00;
`endif

    assign evt_valid = (count_q != '0);
    assign full      = (count_q == DEPTH_C);
    assign pop       = evt_valid && evt_ready;
    // A pop frees the slot in the same cycle, so a push into a full FIFO is still accepted.
    assign wr_en     = push && (!full || pop);

    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            if (wr_en) wr_q <= wr_q + PTR_ONE;
            if (pop)   rd_q <= rd_q + PTR_ONE;
            if (push && full && !pop) ovf_q <= 1'b1;
            else if (ovf_clear)       ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= {push_ext, push_brk, push_code, push_ascii};
    end

    assign head      = mem_q[rd_q];
    assign evt_ext   = evt_valid ? head[17]    : 1'b0;
    assign evt_break = evt_valid ? head[16]    : 1'b0;
    assign evt_code  = evt_valid ? head[15:8]  : 8'h00;
    assign evt_ascii = evt_valid ? head[7:0]   : 8'h00;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder (expects ASCII only when
// PS2_ASCII_LUT_EN is defined).
module tb_ps2_scancode_decoder;

`ifdef PS2_ASCII_LUT_EN
    localparam bit LUT = 1'b1;
`else
    localparam bit LUT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       evt_ready = 1'b0;
    logic       ovf_clear = 1'b0;
    logic       evt_valid, evt_ext, evt_break;
    logic [7:0] evt_code, evt_ascii;
    logic       mod_shift, mod_ctrl, mod_alt, caps_lock, overflow;

    int checks = 0;
    int failures = 0;

    ps2_scancode_decoder #(.FIFO_DEPTH(8), .FIFO_AW(3)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .evt_ready(evt_ready), .ovf_clear(ovf_clear), .evt_valid(evt_valid),
        .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
        .evt_ascii(evt_ascii), .mod_shift(mod_shift), .mod_ctrl(mod_ctrl),
        .mod_alt(mod_alt), .caps_lock(caps_lock), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic ext, input logic brk,
                            input logic [7:0] code, input logic [7:0] ascii);
        chk({tag, ".valid"}, {7'd0, evt_valid}, 8'h01);
        chk({tag, ".ext"},   {7'd0, evt_ext},   {7'd0, ext});
        chk({tag, ".brk"},   {7'd0, evt_break}, {7'd0, brk});
        chk({tag, ".code"},  evt_code, code);
        chk({tag, ".ascii"}, evt_ascii, ascii);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"},  {7'd0, evt_valid}, 8'h00);
        chk({tag, ".code"},   evt_code, 8'h00);
        chk({tag, ".ascii"},  evt_ascii, 8'h00);
        chk({tag, ".flags"},  {2'd0, evt_ext, evt_break, mod_shift, mod_ctrl, mod_alt, caps_lock}, 8'h00);
        chk({tag, ".ovf"},    {7'd0, overflow}, 8'h00);
    endtask

    logic [7:0] fill  [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    logic [7:0] drain [8] = '{8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h4D};

    initial begin
        // Reset state
        #12;
        chk_all_zero("rst");
        @(negedge clk);
        reset = 1'b0;

        // Make / break of 'a'
        send(8'h1C);
        chk_head("a_make", 1'b0, 1'b0, 8'h1C, LUT ? 8'h61 : 8'h00);
        send(8'hF0);
        send(8'h1C);
        pop();
        chk_head("a_brk", 1'b0, 1'b1, 8'h1C, 8'h00);
        pop();
        chk("a_empty", {7'd0, evt_valid}, 8'h00);
        pop();
        chk("pop_empty_ignored", {7'd0, evt_valid}, 8'h00);

        // Shifted 'A'
        send(8'h12);
        chk("shift_set", {7'd0, mod_shift}, 8'h01);
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        send(8'hF0);
        send(8'h12);
        chk("shift_clr", {7'd0, mod_shift}, 8'h00);
        chk_head("sh_ev0", 1'b0, 1'b0, 8'h12, 8'h00);
        pop();
        chk_head("sh_ev1", 1'b0, 1'b0, 8'h1C, LUT ? 8'h41 : 8'h00);
        pop();
        chk_head("sh_ev2", 1'b0, 1'b1, 8'h1C, 8'h00);
        pop();
        chk_head("sh_ev3", 1'b0, 1'b1, 8'h12, 8'h00);
        pop();
        chk("sh_empty", {7'd0, evt_valid}, 8'h00);

        // Extended keys and print-screen fake shift
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk_head("ext_make", 1'b1, 1'b0, 8'h75, 8'h00);
        pop();
        chk_head("ext_brk", 1'b1, 1'b1, 8'h75, 8'h00);
        pop();
        send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
        chk_head("prtsc", 1'b1, 1'b0, 8'h7C, 8'h00);
        chk("prtsc_shift", {7'd0, mod_shift}, 8'h00);
        pop();
        chk("prtsc_empty", {7'd0, evt_valid}, 8'h00);

        // Right ctrl and left alt
        send(8'hE0); send(8'h14);
        chk("rctrl_set", {7'd0, mod_ctrl}, 8'h01);
        send(8'hE0); send(8'hF0); send(8'h14);
        chk("rctrl_clr", {7'd0, mod_ctrl}, 8'h00);
        send(8'h11);
        chk("lalt_set", {7'd0, mod_alt}, 8'h01);
        send(8'hF0); send(8'h11);
        chk("lalt_clr", {7'd0, mod_alt}, 8'h00);
        for (int i = 0; i < 4; i++) pop();
        chk("mods_empty", {7'd0, evt_valid}, 8'h00);

        // Pause sequence
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0);
        chk("pause_pending", {7'd0, evt_valid}, 8'h00);
        send(8'h77);
        chk_head("pause", 1'b1, 1'b0, 8'hE1, 8'h00);
        chk("pause_mods", {5'd0, mod_shift, mod_ctrl, mod_alt}, 8'h00);
        pop();
        chk("pause_single", {7'd0, evt_valid}, 8'h00);

        // Caps lock toggle with typematic repeat
        send(8'h58);
        chk("caps_make", {7'd0, caps_lock}, 8'h01);
        send(8'h58);
        chk("caps_repeat", {7'd0, caps_lock}, 8'h01);
        send(8'hF0); send(8'h58);
        chk("caps_break", {7'd0, caps_lock}, 8'h01);
        send(8'h58);
        chk("caps_retoggle", {7'd0, caps_lock}, 8'h00);
        for (int i = 0; i < 4; i++) pop();
        chk("caps_empty", {7'd0, evt_valid}, 8'h00);

        // Overflow and full-FIFO push+pop
        for (int i = 0; i < 9; i++) send(fill[i]);
        chk("ovf_set", {7'd0, overflow}, 8'h01);
        chk_head("full_head", 1'b0, 1'b0, 8'h15, LUT ? 8'h71 : 8'h00);
        @(negedge clk);
        ovf_clear = 1'b1;
        @(negedge clk);
        ovf_clear = 1'b0;
        chk("ovf_clear", {7'd0, overflow}, 8'h00);
        @(negedge clk);
        evt_ready = 1'b1;
        rx_valid  = 1'b1;
        rx_data   = 8'h4D;
        @(negedge clk);
        evt_ready = 1'b0;
        rx_valid  = 1'b0;
        chk("ovf_pushpop", {7'd0, overflow}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), evt_code, drain[i]);
            pop();
        end
        chk("drain_empty", {7'd0, evt_valid}, 8'h00);

        // Reset mid-sequence discards the F0 prefix
        send(8'h12);
        send(8'hF0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        send(8'h1C);
        chk_head("post_rst", 1'b0, 1'b0, 8'h1C, LUT ? 8'h61 : 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
